// File: rtl/openddr_pkg.sv
// Shared types and constants for the openddr read-return path.
package openddr_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned RD_BUF_DEPTH   = 32;
  // Widest AXI ID a read tag can carry; narrower IDs are zero-extended.
  localparam int unsigned RD_TAG_ID_MAX  = 16;

  typedef struct packed {
    logic [RD_TAG_ID_MAX-1:0] id;
    logic [7:0]               len;
  } rd_tag_t;

endpackage

// File: rtl/openddr_sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
module openddr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; validity is tracked by the reset pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/openddr_rd_return_buffer.sv
// Reassembles 4-phase DFI read data into an AXI R stream, tagged by issued read commands.
module openddr_rd_return_buffer
  import openddr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = RD_BUF_DEPTH,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_cmd_valid,
  output logic                      rd_cmd_ready,
  input  logic [ID_WIDTH-1:0]       rd_cmd_id,
  input  logic [7:0]                rd_cmd_len,
  input  logic [DATA_WIDTH-1:0]     dfi_rddata_0_p0,
  input  logic [DATA_WIDTH-1:0]     dfi_rddata_0_p1,
  input  logic [DATA_WIDTH-1:0]     dfi_rddata_1_p2,
  input  logic [DATA_WIDTH-1:0]     dfi_rddata_1_p3,
  input  logic                      dfi_rddata_valid_0_p0,
  input  logic                      dfi_rddata_valid_0_p1,
  input  logic                      dfi_rddata_valid_1_p2,
  input  logic                      dfi_rddata_valid_1_p3,
  output logic [ID_WIDTH-1:0]       axi_rid,
  output logic [DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rlast,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [$clog2(DEPTH):0]    rd_credit,
  output logic                      overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d, free_cnt;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] ph_data [4];
  logic [3:0]            ph_valid, ph_keep;
  logic [2:0]            ph_pos [4];
  logic [2:0]            n_valid, n_push;

  rd_tag_t                  tag_in, head_tag;
  logic                     tag_full, tag_empty, tag_pop, rd_hs;
  logic [RD_TAG_ID_MAX-1:0] unused_head_id;

  assign ph_data  = '{dfi_rddata_0_p0, dfi_rddata_0_p1, dfi_rddata_1_p2, dfi_rddata_1_p3};
  assign ph_valid = {dfi_rddata_valid_1_p3, dfi_rddata_valid_1_p2,
                     dfi_rddata_valid_0_p1, dfi_rddata_valid_0_p0};

  // Free space is taken before this cycle's pop, so a pop never makes room for same-cycle pushes.
  assign free_cnt = CW'(DEPTH) - occ_q;
  assign rd_credit = free_cnt;

  always_comb begin
    n_valid = '0;
    n_push  = '0;
    for (int i = 0; i < 4; i++) begin
      ph_pos[i]  = n_valid;
      ph_keep[i] = ph_valid[i] && (CW'(n_valid) < free_cnt);
      n_valid    = n_valid + 3'(ph_valid[i]);
      n_push     = n_push + 3'(ph_keep[i]);
    end
  end

  assign tag_in = '{id: RD_TAG_ID_MAX'(rd_cmd_id), len: rd_cmd_len};

  openddr_sync_fifo #(
    .WIDTH ($bits(rd_tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_cmd_valid),
    .din_i   (tag_in),
    .pop_i   (tag_pop),
    .dout_o  (head_tag),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // IDs wider than ID_WIDTH are never pushed; the upper bits exist only in the shared tag type.
  assign unused_head_id = head_tag.id;

  assign rd_cmd_ready = !tag_full;
  assign axi_rvalid   = (occ_q != '0) && !tag_empty;
  assign axi_rlast    = axi_rvalid && (beat_cnt_q == head_tag.len);
  assign axi_rid      = axi_rvalid ? head_tag.id[ID_WIDTH-1:0] : '0;
  assign axi_rdata    = axi_rvalid ? mem_q[rd_ptr_q] : '0;
  assign axi_rresp    = AXI_RESP_OKAY;
  assign rd_hs        = axi_rvalid && axi_rready;
  assign tag_pop      = rd_hs && axi_rlast;
  assign overflow_err = ovf_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(n_push);
    rd_ptr_d   = rd_ptr_q + AW'(rd_hs);
    occ_d      = occ_q + CW'(n_push) - CW'(rd_hs);
    beat_cnt_d = beat_cnt_q;
    if (rd_hs) beat_cnt_d = axi_rlast ? 8'd0 : beat_cnt_q + 8'd1;
    ovf_d      = ovf_q || (n_valid != n_push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ph_keep[i]) mem_q[wr_ptr_q + AW'(ph_pos[i])] <= ph_data[i];
    end
  end

endmodule

// File: tb/tb_openddr_rd_return_buffer.sv
// Directed bench for the read-return buffer: vector table plus multi-cycle corner sequences.
module tb_openddr_rd_return_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_cmd_valid, rd_cmd_ready;
  logic [3:0]  rd_cmd_id;
  logic [7:0]  rd_cmd_len;
  logic [63:0] d_p0, d_p1, d_p2, d_p3;
  logic        v_p0, v_p1, v_p2, v_p3;
  logic [3:0]  axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;
  logic [5:0]  rd_credit;
  logic        overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  openddr_rd_return_buffer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rd_cmd_valid          (rd_cmd_valid),
    .rd_cmd_ready          (rd_cmd_ready),
    .rd_cmd_id             (rd_cmd_id),
    .rd_cmd_len            (rd_cmd_len),
    .dfi_rddata_0_p0       (d_p0),
    .dfi_rddata_0_p1       (d_p1),
    .dfi_rddata_1_p2       (d_p2),
    .dfi_rddata_1_p3       (d_p3),
    .dfi_rddata_valid_0_p0 (v_p0),
    .dfi_rddata_valid_0_p1 (v_p1),
    .dfi_rddata_valid_1_p2 (v_p2),
    .dfi_rddata_valid_1_p3 (v_p3),
    .axi_rid               (axi_rid),
    .axi_rdata             (axi_rdata),
    .axi_rresp             (axi_rresp),
    .axi_rlast             (axi_rlast),
    .axi_rvalid            (axi_rvalid),
    .axi_rready            (axi_rready),
    .rd_credit             (rd_credit),
    .overflow_err          (overflow_err)
  );

  typedef struct {
    logic [3:0] mask;
    logic [3:0] id;
    logic [7:0] len;
    int         n;
    int         ph [4];
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pdata(input int tagv, input int p);
    return 64'hA000_0000_0000_0000 | (64'(tagv) << 8) | 64'(p);
  endfunction

  task automatic set_dfi(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
    {v_p3, v_p2, v_p1, v_p0} = m;
    d_p0 = a; d_p1 = b; d_p2 = c; d_p3 = d;
  endtask

  task automatic check_beat(input string name, input logic [63:0] data, input logic [3:0] id,
                            input logic last);
    check({name, ".rvalid"}, 64'(axi_rvalid), 64'd1);
    check({name, ".rdata"}, axi_rdata, data);
    check({name, ".rid"}, 64'(axi_rid), 64'(id));
    check({name, ".rlast"}, 64'(axi_rlast), 64'(last));
  endtask

  initial begin
    // mask bit i = phase pi valid; ph[] lists the phases in the order the beats must come out
    vecs[0] = '{mask: 4'b1111, id: 4'd3, len: 8'd3, n: 4, ph: '{0, 1, 2, 3}};
    vecs[1] = '{mask: 4'b1010, id: 4'd2, len: 8'd1, n: 2, ph: '{1, 3, 0, 0}};
    vecs[2] = '{mask: 4'b0001, id: 4'd7, len: 8'd0, n: 1, ph: '{0, 0, 0, 0}};
    vecs[3] = '{mask: 4'b0110, id: 4'd1, len: 8'd1, n: 2, ph: '{1, 2, 0, 0}};
    vecs[4] = '{mask: 4'b1000, id: 4'd9, len: 8'd0, n: 1, ph: '{3, 0, 0, 0}};
    vecs[5] = '{mask: 4'b1101, id: 4'd4, len: 8'd2, n: 3, ph: '{0, 2, 3, 0}};

    rst_n = 1'b0;
    rd_cmd_valid = 1'b0; rd_cmd_id = '0; rd_cmd_len = '0;
    axi_rready = 1'b1;
    set_dfi(4'b0000, '0, '0, '0, '0);
    #2;
    check("rst.rvalid", 64'(axi_rvalid), 64'd0);
    check("rst.rlast", 64'(axi_rlast), 64'd0);
    check("rst.rid", 64'(axi_rid), 64'd0);
    check("rst.rdata", axi_rdata, 64'd0);
    check("rst.rresp", 64'(axi_rresp), 64'd0);
    check("rst.credit", 64'(rd_credit), 64'd32);
    check("rst.cmd_ready", 64'(rd_cmd_ready), 64'd1);
    check("rst.ovf", 64'(overflow_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: one command plus one DFI cycle, drained with rready held high.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      rd_cmd_valid = 1'b1; rd_cmd_id = vecs[v].id; rd_cmd_len = vecs[v].len;
      set_dfi(vecs[v].mask, pdata(v, 0), pdata(v, 1), pdata(v, 2), pdata(v, 3));
      @(posedge clk); #1;
      rd_cmd_valid = 1'b0;
      set_dfi(4'b0000, '0, '0, '0, '0);
      for (int j = 0; j < vecs[v].n; j++) begin
        @(negedge clk);
        check_beat($sformatf("vec%0d.b%0d", v, j), pdata(v, vecs[v].ph[j]), vecs[v].id,
                   j == vecs[v].n - 1);
      end
      check($sformatf("vec%0d.rresp", v), 64'(axi_rresp), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d.idle", v), 64'(axi_rvalid), 64'd0);
      check($sformatf("vec%0d.credit", v), 64'(rd_credit), 64'd32);
    end

    // Backpressure: outputs frozen for 5 cycles, then the burst resumes in order.
    axi_rready = 1'b0;
    @(posedge clk); #1;
    rd_cmd_valid = 1'b1; rd_cmd_id = 4'd6; rd_cmd_len = 8'd2;
    set_dfi(4'b0111, pdata(10, 0), pdata(10, 1), pdata(10, 2), pdata(10, 3));
    @(posedge clk); #1;
    rd_cmd_valid = 1'b0;
    set_dfi(4'b0000, '0, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_beat($sformatf("bp.hold%0d", k), pdata(10, 0), 4'd6, 1'b0);
    end
    check("bp.credit", 64'(rd_credit), 64'd29);
    axi_rready = 1'b1;
    for (int j = 1; j < 3; j++) begin
      @(negedge clk);
      check_beat($sformatf("bp.b%0d", j), pdata(10, j), 4'd6, j == 2);
    end
    @(negedge clk);
    check("bp.idle", 64'(axi_rvalid), 64'd0);

    // Data before tag: beats wait until the cycle after the tag is pushed.
    @(posedge clk); #1;
    set_dfi(4'b0011, pdata(11, 0), pdata(11, 1), '0, '0);
    @(posedge clk); #1;
    set_dfi(4'b0000, '0, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("dbt.wait%0d", k), 64'(axi_rvalid), 64'd0);
    end
    check("dbt.credit", 64'(rd_credit), 64'd30);
    @(posedge clk); #1;
    rd_cmd_valid = 1'b1; rd_cmd_id = 4'd5; rd_cmd_len = 8'd1;
    @(negedge clk);
    check("dbt.push_cycle", 64'(axi_rvalid), 64'd0);
    @(posedge clk); #1;
    rd_cmd_valid = 1'b0;
    @(negedge clk);
    check_beat("dbt.b0", pdata(11, 0), 4'd5, 1'b0);
    @(negedge clk);
    check_beat("dbt.b1", pdata(11, 1), 4'd5, 1'b1);
    @(negedge clk);
    check("dbt.idle", 64'(axi_rvalid), 64'd0);

    // Overflow: fill to 30 with no tag, then four beats of which only p0/p1 fit.
    axi_rready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      set_dfi(4'b1111, 64'(4*c), 64'(4*c+1), 64'(4*c+2), 64'(4*c+3));
    end
    @(posedge clk); #1;
    set_dfi(4'b0011, 64'd28, 64'd29, '0, '0);
    @(posedge clk); #1;
    set_dfi(4'b0000, '0, '0, '0, '0);
    @(negedge clk);
    check("ovf.credit30", 64'(rd_credit), 64'd2);
    check("ovf.clear", 64'(overflow_err), 64'd0);
    @(posedge clk); #1;
    set_dfi(4'b1111, 64'd100, 64'd101, 64'd102, 64'd103);
    @(posedge clk); #1;
    set_dfi(4'b0000, '0, '0, '0, '0);
    @(negedge clk);
    check("ovf.flag", 64'(overflow_err), 64'd1);
    check("ovf.credit0", 64'(rd_credit), 64'd0);
    @(posedge clk); #1;
    rd_cmd_valid = 1'b1; rd_cmd_id = 4'd1; rd_cmd_len = 8'd31;
    axi_rready = 1'b1;
    @(posedge clk); #1;
    rd_cmd_valid = 1'b0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      check($sformatf("ovf.d%0d", j), axi_rdata, (j < 30) ? 64'(j) : 64'(100 + j - 30));
      check($sformatf("ovf.l%0d", j), 64'(axi_rlast), 64'(j == 31));
    end
    @(negedge clk);
    check("ovf.idle", 64'(axi_rvalid), 64'd0);
    check("ovf.credit32", 64'(rd_credit), 64'd32);
    check("ovf.sticky", 64'(overflow_err), 64'd1);

    // Tag FIFO full drops rd_cmd_ready; reset restores it and clears the sticky flag.
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      rd_cmd_valid = 1'b1; rd_cmd_id = 4'(t); rd_cmd_len = 8'd0;
    end
    @(posedge clk); #1;
    rd_cmd_valid = 1'b0;
    @(negedge clk);
    check("tagfull.ready", 64'(rd_cmd_ready), 64'd0);
    check("tagfull.rvalid", 64'(axi_rvalid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("tagfull.rst_ready", 64'(rd_cmd_ready), 64'd1);
    check("tagfull.rst_ovf", 64'(overflow_err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset mid-burst after two beats of a len=7 burst.
    @(posedge clk); #1;
    rd_cmd_valid = 1'b1; rd_cmd_id = 4'd2; rd_cmd_len = 8'd7;
    set_dfi(4'b1111, pdata(12, 0), pdata(12, 1), pdata(12, 2), pdata(12, 3));
    @(posedge clk); #1;
    rd_cmd_valid = 1'b0;
    set_dfi(4'b1111, pdata(12, 4), pdata(12, 5), pdata(12, 6), pdata(12, 7));
    @(posedge clk); #1;
    set_dfi(4'b0000, '0, '0, '0, '0);
    @(negedge clk);
    check_beat("mid.b1", pdata(12, 1), 4'd2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid.rst_rvalid", 64'(axi_rvalid), 64'd0);
    check("mid.rst_credit", 64'(rd_credit), 64'd32);
    check("mid.rst_rlast", 64'(axi_rlast), 64'd0);
    check("mid.rst_rdata", axi_rdata, 64'd0);
    check("mid.rst_rid", 64'(axi_rid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mid.after%0d.rvalid", k), 64'(axi_rvalid), 64'd0);
      check($sformatf("mid.after%0d.credit", k), 64'(rd_credit), 64'd32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/openddr_rd_return_buffer.md
OPENDDR_RD_RETURN_BUFFER -- requirements
Module: openddr_rd_return_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, is the read data beat width in bits.
REQ-002 Parameter ID_WIDTH, default 4, is the AXI ID width in bits.
REQ-003 Parameter DEPTH, default 32, is the number of beat entries in the data buffer; it SHALL be a power of two and at least 8.
REQ-004 Parameter TAG_DEPTH, default 8, is the number of outstanding read commands tracked; it SHALL be a power of two.
REQ-005 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rd_cmd_valid / rd_cmd_ready  in / out  1 / 1  handshake for issued read commands.
REQ-008 rd_cmd_id  in  ID_WIDTH  AXI ID of the issued read.
REQ-009 rd_cmd_len  in  8  AXI length of the issued read; the beat count is rd_cmd_len+1.
REQ-010 dfi_rddata_0_p0, dfi_rddata_0_p1, dfi_rddata_1_p2, dfi_rddata_1_p3  in  DATA_WIDTH each  DFI read data, one bus per phase.
REQ-011 dfi_rddata_valid_0_p0, dfi_rddata_valid_0_p1, dfi_rddata_valid_1_p2, dfi_rddata_valid_1_p3  in  1 each  per-phase valid for the matching data bus.
REQ-012 axi_rid  out  ID_WIDTH  ID of the head beat.
REQ-013 axi_rdata  out  DATA_WIDTH  data of the head beat.
REQ-014 axi_rresp  out  2  response; always 2'b00 (OKAY).
REQ-015 axi_rlast  out  1  marks the final beat of a burst.
REQ-016 axi_rvalid / axi_rready  out / in  1 / 1  AXI R channel handshake.
REQ-017 rd_credit  out  $clog2(DEPTH)+1  number of free data entries, equal to DEPTH minus occupancy.
REQ-018 overflow_err  out  1  sticky flag; set when any DFI beat is dropped.

Function
REQ-019 Each cycle, the block SHALL write every valid phase beat into the data buffer in phase order p0, p1, p2, p3, compacted with no holes; 0-4 beats per cycle.
REQ-020 Write-pointer and occupancy updates:
- write pointer advances by the number of beats written;
- pointers wrap modulo DEPTH;
- occupancy next = occupancy + pushes - pop, where pop is 0 or 1.
REQ-021 If the number of valid beats exceeds the free space, the block SHALL:
- store beats in phase order until the buffer is full;
- drop the remainder;
- set overflow_err.
REQ-022 A pop in the same cycle SHALL NOT free space for that cycle's pushes.
REQ-023 The command tag FIFO SHALL accept {rd_cmd_id, rd_cmd_len} when rd_cmd_valid && rd_cmd_ready.
REQ-024 rd_cmd_ready SHALL be 1 exactly when the tag FIFO is not full.
REQ-025 axi_rvalid SHALL be 1 exactly when data occupancy > 0 and the tag FIFO is non-empty; it is driven from registered state only.
REQ-026 A beat written in cycle N SHALL be presentable on the R channel in cycle N+1, with no combinational DFI-to-R path.
REQ-027 axi_rdata SHALL be the entry at the read pointer. axi_rid SHALL be the head tag's ID.
REQ-028 A beat counter SHALL count handshakes within the head burst. axi_rlast SHALL be 1 exactly when the beat counter equals the head tag's len.
REQ-029 On a handshake (axi_rvalid && axi_rready):
- advance the read pointer;
- if axi_rlast is 1, pop the tag FIFO and clear the beat counter; otherwise increment the beat counter.
REQ-030 R outputs SHALL hold stable while axi_rvalid && !axi_rready.
REQ-031 Beats arriving with no tag pending SHALL be buffered and held until a tag arrives.
REQ-032 A tag push and a tag pop in the same cycle SHALL both complete; tag occupancy is then unchanged.
REQ-033 overflow_err SHALL clear only on reset.

Reset
REQ-034 While rst_n=0, the block SHALL hold all of the following, asynchronously:
- pointers, occupancies and beat counter = 0;
- overflow_err = 0;
- axi_rvalid = 0, axi_rlast = 0;
- axi_rid = 0, axi_rdata = 0, axi_rresp = 0;
- rd_credit = DEPTH;
- rd_cmd_ready = 1.
REQ-035 Data storage SHALL need no reset.
REQ-036 Reset asserted mid-burst SHALL discard all buffered beats and tags. No partial burst SHALL be emitted after reset release.

Structure
REQ-037 openddr_pkg SHALL hold:
- the rd_tag_t struct {id, len};
- the constants AXI_RESP_OKAY=2'b00 and RD_BUF_DEPTH=32.
REQ-038 The tag FIFO SHALL be a sub-module, openddr_sync_fifo, parameterised by width and depth, that exposes full and empty.
REQ-039 The data buffer, compaction logic and beat counter SHALL reside in this module.

Verification
REQ-040 Single-burst reassembly:
- stimulus: cmd id=3 len=3; one cycle with all four phases valid, data A0..A3; axi_rready=1;
- required response: R beats A0, A1, A2, A3 with rid=3 in cycles N+1..N+4; rlast only on A3; rd_credit returns to 32.
REQ-041 Sparse phase compaction:
- stimulus: only p1 and p3 valid, data B1, B3; cmd len=1;
- required response: beats B1 then B3; rlast on B3.
REQ-042 Backpressure:
- stimulus: axi_rready=0 for 5 cycles after rvalid rises;
- required response: rdata, rid and rlast held constant; no beat lost; the sequence resumes in order.
REQ-043 Overflow:
- stimulus: fill to occupancy 30; then all four phases valid;
- required response: p0 and p1 stored; p2 and p3 dropped; overflow_err=1; rd_credit=0.
REQ-044 Data before tag:
- stimulus: 2 beats arrive; tag id=5 len=1 arrives 3 cycles later;
- required response: rvalid stays 0 until the cycle after the tag push; then rid=5.
REQ-045 Reset mid-burst:
- stimulus: assert rst_n=0 after beat 2 of a len=7 burst;
- required response: rvalid=0 and rd_credit=32 immediately; no residual beats after reset release.
